// File: rtl/coproc_arbiter_pkg.sv
// Shared definitions for the coprocessor arbiter: FSM states, requester
// identities and default tuning constants.
package coproc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_HPS = 1'b0,
    OWN_IPU = 1'b1
  } owner_e;

  localparam int unsigned DEFAULT_IPU_BURST = 4;
  localparam int unsigned DEFAULT_TIMEOUT   = 1024;

  function automatic logic [31:0] pick_instruction(input owner_e      who,
                                                   input logic [31:0] hps_instr,
                                                   input logic [31:0] ipu_instr);
    return (who == OWN_IPU) ? ipu_instr : hps_instr;
  endfunction

endpackage

// File: rtl/coproc_arbiter_rr_burst_picker.sv
// Winner selection between HPS and IPU: IPU is preferred, but after IPU_BURST
// consecutive IPU grants with HPS waiting, HPS gets the next slot.
module rr_burst_picker
  import coproc_arbiter_pkg::*;
#(
  parameter int unsigned IPU_BURST = DEFAULT_IPU_BURST
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hps_valid_i,
  input  logic   ipu_valid_i,
  input  logic   grant_i,
  output owner_e winner_o
);

  localparam int unsigned CW = (IPU_BURST > 0) ? $clog2(IPU_BURST + 1) : 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(IPU_BURST);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          burst_full;

  assign burst_full = (burst_cnt_q == BURST_MAX);

  always_comb begin
    winner_o = OWN_HPS;
    if (ipu_valid_i && !(hps_valid_i && burst_full)) begin
      winner_o = OWN_IPU;
    end
  end

  // The count only measures how long HPS has been starved, so any grant made
  // while HPS is not waiting restarts it.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (grant_i) begin
      if (winner_o == OWN_HPS || !hps_valid_i) begin
        burst_cnt_d = '0;
      end else if (!burst_full) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/coproc_arbiter.sv
// Arbitrates HPS and IPU instruction requests onto a single coprocessor,
// tracking each operation through its busy handshake with a wait timeout.
module coproc_arbiter
  import coproc_arbiter_pkg::*;
#(
  parameter int unsigned IPU_BURST = DEFAULT_IPU_BURST,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] hps_instruction,
  input  logic        hps_valid,
  output logic        hps_ready,
  output logic        hps_done,
  input  logic [31:0] ipu_instruction,
  input  logic        ipu_valid,
  output logic        ipu_ready,
  output logic        ipu_done,
  output logic [31:0] cop_instruction,
  output logic        cop_activate,
  output logic        cop_ipu_request,
  input  logic        cop_wait,
  output logic        owner,
  output logic        timeout_err
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  owner_e        winner;
  logic          grant;
  logic          done_hit;
  logic          timeout_hit;

  owner_e        owner_q, owner_d;
  logic [31:0]   cop_instr_q, cop_instr_d;
  logic          cop_activate_q, cop_activate_d;
  logic          cop_ipu_req_q, cop_ipu_req_d;
  logic          hps_ready_q, hps_ready_d;
  logic          ipu_ready_q, ipu_ready_d;
  logic          hps_done_q, hps_done_d;
  logic          ipu_done_q, ipu_done_d;
  logic          timeout_err_q, timeout_err_d;

  rr_burst_picker #(
    .IPU_BURST (IPU_BURST)
  ) u_picker (
    .clk         (clk),
    .reset       (reset),
    .hps_valid_i (hps_valid),
    .ipu_valid_i (ipu_valid),
    .grant_i     (grant),
    .winner_o    (winner)
  );

  // The coprocessor is never reset, so the state register returns to IDLE and
  // the cop_wait gate there keeps a still-busy coprocessor from being reissued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      owner_q        <= OWN_HPS;
      cop_instr_q    <= '0;
      cop_activate_q <= 1'b0;
      cop_ipu_req_q  <= 1'b0;
      hps_ready_q    <= 1'b0;
      ipu_ready_q    <= 1'b0;
      hps_done_q     <= 1'b0;
      ipu_done_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      owner_q        <= owner_d;
      cop_instr_q    <= cop_instr_d;
      cop_activate_q <= cop_activate_d;
      cop_ipu_req_q  <= cop_ipu_req_d;
      hps_ready_q    <= hps_ready_d;
      ipu_ready_q    <= ipu_ready_d;
      hps_done_q     <= hps_done_d;
      ipu_done_q     <= ipu_done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    grant       = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cop_wait && (hps_valid || ipu_valid)) begin
          grant   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT_START;
        wait_cnt_d = '0;
      end
      ST_WAIT_START: begin
        if (cop_wait) begin
          state_d    = ST_WAIT_DONE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = ST_IDLE;
          timeout_hit = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!cop_wait) begin
          state_d  = ST_IDLE;
          done_hit = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = ST_IDLE;
          timeout_hit = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every output is the registered image of a value computed here from the
  // upcoming state, so pulses line up with the state they describe.
  always_comb begin
    owner_d     = owner_q;
    cop_instr_d = cop_instr_q;
    if (grant) begin
      owner_d     = winner;
      cop_instr_d = pick_instruction(winner, hps_instruction, ipu_instruction);
    end
    cop_activate_d = grant;
    hps_ready_d    = grant && (winner == OWN_HPS);
    ipu_ready_d    = grant && (winner == OWN_IPU);
    hps_done_d     = done_hit && (owner_q == OWN_HPS);
    ipu_done_d     = done_hit && (owner_q == OWN_IPU);
    cop_ipu_req_d  = (state_d != ST_IDLE) && (owner_d == OWN_IPU);
    timeout_err_d  = timeout_err_q || timeout_hit;
  end

  assign cop_instruction = cop_instr_q;
  assign cop_activate    = cop_activate_q;
  assign cop_ipu_request = cop_ipu_req_q;
  assign hps_ready       = hps_ready_q;
  assign ipu_ready       = ipu_ready_q;
  assign hps_done        = hps_done_q;
  assign ipu_done        = ipu_done_q;
  assign owner           = owner_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_coproc_arbiter.sv
// Directed bench for coproc_arbiter with a small coprocessor busy model;
// inputs are driven and outputs sampled on the falling clock edge.
module tb_coproc_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hps_instruction;
  logic        hps_valid;
  logic        hps_ready;
  logic        hps_done;
  logic [31:0] ipu_instruction;
  logic        ipu_valid;
  logic        ipu_ready;
  logic        ipu_done;
  logic [31:0] cop_instruction;
  logic        cop_activate;
  logic        cop_ipu_request;
  logic        cop_wait = 1'b0;
  logic        owner;
  logic        timeout_err;

  int   errors = 0;
  int   checks = 0;
  int   busyLen = 1;
  int   busyLeft = 0;
  logic copMute = 1'b0;

  coproc_arbiter #(
    .IPU_BURST (4),
    .TIMEOUT   (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .hps_instruction (hps_instruction),
    .hps_valid       (hps_valid),
    .hps_ready       (hps_ready),
    .hps_done        (hps_done),
    .ipu_instruction (ipu_instruction),
    .ipu_valid       (ipu_valid),
    .ipu_ready       (ipu_ready),
    .ipu_done        (ipu_done),
    .cop_instruction (cop_instruction),
    .cop_activate    (cop_activate),
    .cop_ipu_request (cop_ipu_request),
    .cop_wait        (cop_wait),
    .owner           (owner),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  // Coprocessor stand-in: raises busy for busyLen cycles after each strobe
  // unless muted, and is deliberately unaffected by the arbiter reset.
  always @(posedge clk) begin
    if (cop_activate && !copMute) begin
      cop_wait <= 1'b1;
      busyLeft <= busyLen;
    end else if (busyLeft > 1) begin
      busyLeft <= busyLeft - 1;
    end else if (busyLeft == 1) begin
      busyLeft <= 0;
      cop_wait <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic hv, input logic [31:0] hi,
                               input logic iv, input logic [31:0] ii);
    hps_valid       = hv;
    hps_instruction = hi;
    ipu_valid       = iv;
    ipu_instruction = ii;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [9:0]  expOrder;
    logic [31:0] hpsInstr;
    logic [31:0] ipuInstr;
    int          grants;
    logic        sawDone;
    logic        sawAct;

    expOrder = 10'b0111101111;
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(3);
    checkOutput("rstActivate", 32'(cop_activate), 32'd0);
    checkOutput("rstReady", 32'({hps_ready, ipu_ready}), 32'd0);
    checkOutput("rstDone", 32'({hps_done, ipu_done}), 32'd0);
    checkOutput("rstIpuReq", 32'(cop_ipu_request), 32'd0);
    checkOutput("rstOwner", 32'(owner), 32'd0);
    checkOutput("rstTimeout", 32'(timeout_err), 32'd0);
    checkOutput("rstInstr", cop_instruction, 32'd0);
    reset = 1'b0;
    tick(1);

    $display("[TB] single HPS request, busy 3 cycles");
    busyLen = 3;
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 32'd0);
    tick(1);
    checkOutput("hpsReady", 32'(hps_ready), 32'd1);
    checkOutput("hpsActivate", 32'(cop_activate), 32'd1);
    checkOutput("hpsIpuReadyLow", 32'(ipu_ready), 32'd0);
    checkOutput("hpsInstr", cop_instruction, 32'hA5A5_0001);
    checkOutput("hpsOwner", 32'(owner), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(1);
    checkOutput("hpsActivateOnce", 32'(cop_activate), 32'd0);
    checkOutput("hpsIpuReq", 32'(cop_ipu_request), 32'd0);
    tick(3);
    checkOutput("hpsDoneEarly", 32'(hps_done), 32'd0);
    tick(1);
    checkOutput("hpsDone", 32'(hps_done), 32'd1);
    checkOutput("hpsNoIpuDone", 32'(ipu_done), 32'd0);
    tick(1);
    checkOutput("hpsDonePulse", 32'(hps_done), 32'd0);

    $display("[TB] single IPU request, busy 1 cycle");
    busyLen = 1;
    applyStimulus(1'b0, 32'd0, 1'b1, 32'hBEEF_0002);
    tick(1);
    checkOutput("ipuReady", 32'(ipu_ready), 32'd1);
    checkOutput("ipuReqIssue", 32'(cop_ipu_request), 32'd1);
    checkOutput("ipuOwner", 32'(owner), 32'd1);
    checkOutput("ipuInstr", cop_instruction, 32'hBEEF_0002);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(1);
    checkOutput("ipuReqWaitStart", 32'(cop_ipu_request), 32'd1);
    tick(1);
    checkOutput("ipuReqWaitDone", 32'(cop_ipu_request), 32'd1);
    tick(1);
    checkOutput("ipuDone", 32'(ipu_done), 32'd1);
    checkOutput("ipuReqDropped", 32'(cop_ipu_request), 32'd0);
    tick(1);
    checkOutput("ipuDonePulse", 32'(ipu_done), 32'd0);

    $display("[TB] both requesters valid, burst limit 4");
    hpsInstr = 32'h0000_0100;
    ipuInstr = 32'h0000_0200;
    applyStimulus(1'b1, hpsInstr, 1'b1, ipuInstr);
    grants = 0;
    for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
      tick(1);
      if (hps_ready || ipu_ready) begin
        checkOutput("readyExclusive", 32'(hps_ready & ipu_ready), 32'd0);
        checkOutput($sformatf("grantOrder%0d", grants), 32'(ipu_ready),
                    32'(expOrder[grants]));
        checkOutput($sformatf("grantInstr%0d", grants), cop_instruction,
                    expOrder[grants] ? ipuInstr : hpsInstr);
        if (ipu_ready) ipuInstr = ipuInstr + 32'd1;
        else           hpsInstr = hpsInstr + 32'd1;
        grants++;
        applyStimulus(grants < 10, hpsInstr, grants < 10, ipuInstr);
      end
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("grantCount", 32'(grants), 32'd10);
    tick(3);
    checkOutput("burstLastDone", 32'(hps_done), 32'd1);
    tick(1);

    $display("[TB] back-to-back HPS requests");
    applyStimulus(1'b1, 32'h0000_0011, 1'b0, 32'd0);
    tick(1);
    checkOutput("b2bFirstAct", 32'(cop_activate), 32'd1);
    checkOutput("b2bFirstInstr", cop_instruction, 32'h0000_0011);
    applyStimulus(1'b1, 32'h0000_0022, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checkOutput("b2bGapAct", 32'(cop_activate), 32'd0);
      checkOutput("b2bHoldInstr", cop_instruction, 32'h0000_0011);
    end
    tick(1);
    checkOutput("b2bSecondAct", 32'(cop_activate), 32'd1);
    checkOutput("b2bSecondReady", 32'(hps_ready), 32'd1);
    checkOutput("b2bSecondInstr", cop_instruction, 32'h0000_0022);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(3);
    checkOutput("b2bSecondDone", 32'(hps_done), 32'd1);
    tick(1);

    $display("[TB] coprocessor never responds, timeout 16");
    copMute = 1'b1;
    applyStimulus(1'b1, 32'h0000_0033, 1'b0, 32'd0);
    tick(1);
    checkOutput("toActivate", 32'(cop_activate), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    sawDone = 1'b0;
    repeat (16) begin
      tick(1);
      sawDone = sawDone | hps_done | ipu_done;
    end
    checkOutput("toNotYet", 32'(timeout_err), 32'd0);
    tick(1);
    sawDone = sawDone | hps_done | ipu_done;
    checkOutput("toSet", 32'(timeout_err), 32'd1);
    checkOutput("toNoDone", 32'(sawDone), 32'd0);
    copMute = 1'b0;
    busyLen = 1;
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0066);
    tick(1);
    checkOutput("toBackToIdle", 32'(ipu_ready), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(3);
    checkOutput("toNextDone", 32'(ipu_done), 32'd1);
    checkOutput("toSticky", 32'(timeout_err), 32'd1);
    tick(1);

    $display("[TB] reset during WAIT_DONE with coprocessor still busy");
    busyLen = 13;
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0000_0044);
    tick(1);
    checkOutput("rmReady", 32'(ipu_ready), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("rmIpuReqClr", 32'(cop_ipu_request), 32'd0);
    checkOutput("rmTimeoutClr", 32'(timeout_err), 32'd0);
    checkOutput("rmInstrClr", cop_instruction, 32'd0);
    checkOutput("rmOwnerClr", 32'(owner), 32'd0);
    busyLen = 1;
    applyStimulus(1'b1, 32'h0000_0055, 1'b0, 32'd0);
    sawDone = ipu_done | hps_done;
    sawAct  = cop_activate;
    repeat (10) begin
      tick(1);
      sawDone = sawDone | hps_done | ipu_done;
      sawAct  = sawAct | cop_activate;
    end
    checkOutput("rmNoDone", 32'(sawDone), 32'd0);
    checkOutput("rmBlockedWhileBusy", 32'(sawAct), 32'd0);
    tick(1);
    checkOutput("rmResumeAct", 32'(cop_activate), 32'd1);
    checkOutput("rmResumeReady", 32'(hps_ready), 32'd1);
    checkOutput("rmResumeInstr", cop_instruction, 32'h0000_0055);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    tick(3);
    checkOutput("rmResumeDone", 32'(hps_done), 32'd1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
